acu_seq: RTL and testbench
==========================

# acu_seq

Sequencer and two-way arbiter for the 16-bit address control unit. It accepts 16-bit address requests from two requesters (port 0: instruction fetch, port 1: data access) and arbitrates between them round-robin. It loads the winning address into the ACU over its 8-bit byte bus: low byte, then high byte. It then enables the ACU output for a fixed window and signals completion. It sits between the core control logic and the ACU; it is the only driver of the ACU's `d`, `wl`, `wh` and `oe` inputs.

## Interface
- `HOLD_CYCLES`, default 2: number of cycles `acu_oe` stays asserted per transaction; legal range 1..15.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `req0  in  1`: request from port 0; hold high with `addr0` stable until `done0`.
- `addr0  in  16`: port 0 address.
- `req1  in  1`: request from port 1; same rules as port 0.
- `addr1  in  16`: port 1 address.
- `gnt0`, `gnt1`  out  1 each: port owns the ACU; high from the first load cycle through the last `acu_oe` cycle.
- `done0`, `done1`  out  1 each: one-cycle completion pulse, coincident with the last `acu_oe` cycle.
- `busy  out  1`: state is not IDLE.
- `acu_d  out  8`: byte bus to the ACU `d` input.
- `acu_wl  out  1`: ACU low-byte write strobe.
- `acu_wh  out  1`: ACU high-byte write strobe.
- `acu_oe  out  1`: ACU output enable.

## Operation
- States: IDLE, LOAD_LO, LOAD_HI, DRIVE.
- IDLE: if any request is pending, latch the winner's address into an internal 16-bit register, set its `gnt`, and go to LOAD_LO. Otherwise stay.
- Arbitration:
  - Only one request pending: that port wins.
  - Both pending: the port not granted last time wins.
  - The last-grant pointer resets to port 1, so port 0 wins the first tie.
- LOAD_LO: `acu_d` = latched[7:0], `acu_wl` = 1; go to LOAD_HI.
- LOAD_HI: `acu_d` = latched[15:8], `acu_wh` = 1; go to DRIVE.
- DRIVE:
  - `acu_oe` = 1 for exactly `HOLD_CYCLES` cycles, counted by a 4-bit counter.
  - On the final cycle, pulse the owner's `done`, then return to IDLE.
  - `gnt` drops with the IDLE transition.
- The address is latched at grant. Changes on `addrN` after grant have no effect.
- A `req` dropped mid-transaction does not abort it; `done` still pulses.
- A `req` still high the cycle after `done` is a new request and goes through arbitration.
- At most one of `acu_wl`, `acu_wh`, `acu_oe` is high in any cycle. `gnt0` and `gnt1` are never both high.
- In IDLE, `acu_d` holds its last value; it is not a bus.
- All outputs are registered.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE; all outputs 0, including `acu_d` = 8'h00; pointer = port 1; latched address = 0; high-byte-valid flag cleared.
- Reset asserted mid-transaction: outputs drop immediately and no `done` is issued. After release, a request still held is re-arbitrated from scratch.
- Request seen at edge N:
  - `gnt` and `acu_wl` high in cycle N+1.
  - `acu_wh` high in cycle N+2.
  - `acu_oe` high in cycles N+3 through N+2+`HOLD_CYCLES`.
  - `done` high in cycle N+2+`HOLD_CYCLES`.
- Back-to-back transactions: the earliest next grant is the cycle after `done`, because IDLE takes one cycle. Throughput is one transaction per `HOLD_CYCLES`+3 cycles.

## Configuration
- `ACU_SEQ_HI_SKIP_EN`
  - Defined:
    - The sequencer keeps the last high byte written plus a valid flag (cleared by reset).
    - If the valid flag is set and the new latched[15:8] equals the stored byte, LOAD_HI is skipped and LOAD_LO goes directly to DRIVE.
    - Latency shrinks by 1 cycle.
    - The stored byte updates on every LOAD_HI.
  - Not defined: every transaction runs LOAD_HI, and the skip logic is absent.

## Test plan
- **Reset values:** `rst_n` low -> all outputs 0. Then `req0`=1, `addr0`=16'h4064 with `HOLD_CYCLES`=2 -> `acu_wl`=1 with `acu_d`=8'h64, then `acu_wh`=1 with `acu_d`=8'h40, then `acu_oe` high 2 cycles, `done0` on the 2nd.
- **Tie and round-robin:** `req0` and `req1` rise together, `addr0`=16'h1111, `addr1`=16'h2222, both held -> port 0 served first, then port 1, then port 0 again. `gnt0` and `gnt1` are never both high.
- **Mid-transaction changes:** `addr0` changed to 16'hFFFF and `req0` dropped during LOAD_HI of a 16'h0020 transaction -> `acu_d` still 8'h00 in LOAD_HI, `done0` still pulses, no new grant follows.
- **Reset mid-operation:** `rst_n` pulsed low during DRIVE -> `acu_oe`, `gnt0`, `busy` drop asynchronously with no `done0`. After release with `req0` held, a full sequence restarts from LOAD_LO.
- **High-byte skip:** with `ACU_SEQ_HI_SKIP_EN` defined, transactions 16'h2010 then 16'h2033 -> the second has no `acu_wh` cycle and `done` arrives 1 cycle earlier. Next, 16'h2133 -> `acu_wh` present with `acu_d`=8'h21. Without the macro, all three include LOAD_HI.
- **Boundary hold:** `HOLD_CYCLES`=1 -> `acu_oe` and `done` both high in exactly one cycle. Transaction length is 4 cycles (3 with skip).

Source files
------------

// File: rtl/acu_seq.sv
// acu_seq: two-port round-robin sequencer that loads a 16-bit address into the ACU byte by byte and enables its output.
// Optional feature macro ACU_SEQ_HI_SKIP_EN: skip the high-byte load when it matches the last high byte written.
module acu_seq #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] addr0,
    input  logic        req1,
    input  logic [15:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic [7:0]  acu_d,
    output logic        acu_wl,
    output logic        acu_wh,
    output logic        acu_oe
);

    typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, DRIVE} state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

    state_t      state_reg;
    logic [15:0] addr_reg;
    logic        owner_reg;
    logic        last_gnt_reg;
    logic [3:0]  cnt_reg;
    logic        winner;
    logic        skip_hi;
    logic        start_drive;
    logic        hold_one;

    // On a tie the port that was not served last time wins.
    assign winner      = (req0 && req1) ? ~last_gnt_reg : req1;
    assign start_drive = (state_reg == LOAD_HI) || ((state_reg == LOAD_LO) && skip_hi);
    assign hold_one    = (HOLD == 4'd1);

`ifdef ACU_SEQ_HI_SKIP_EN
    logic [7:0] hi_byte_reg;
    logic       hi_valid_reg;

    assign skip_hi = hi_valid_reg && (hi_byte_reg == addr_reg[15:8]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte_reg  <= 8'h00;
            hi_valid_reg <= 1'b0;
        end else if ((state_reg == LOAD_LO) && !skip_hi) begin
            hi_byte_reg  <= addr_reg[15:8];
            hi_valid_reg <= 1'b1;
        end
    end
`else
    assign skip_hi = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= 16'h0000;
            owner_reg    <= 1'b0;
            last_gnt_reg <= 1'b1;
            cnt_reg      <= 4'd0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            busy         <= 1'b0;
            acu_d        <= 8'h00;
            acu_wl       <= 1'b0;
            acu_wh       <= 1'b0;
            acu_oe       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        state_reg    <= LOAD_LO;
                        owner_reg    <= winner;
                        last_gnt_reg <= winner;
                        addr_reg     <= winner ? addr1 : addr0;
                        acu_d        <= winner ? addr1[7:0] : addr0[7:0];
                        acu_wl       <= 1'b1;
                        gnt0         <= ~winner;
                        gnt1         <= winner;
                        busy         <= 1'b1;
                    end
                end
                LOAD_LO: begin
                    acu_wl <= 1'b0;
                    if (skip_hi) begin
                        state_reg <= DRIVE;
                    end else begin
                        state_reg <= LOAD_HI;
                        acu_d     <= addr_reg[15:8];
                        acu_wh    <= 1'b1;
                    end
                end
                LOAD_HI: begin
                    acu_wh    <= 1'b0;
                    state_reg <= DRIVE;
                end
                DRIVE: begin
                    if (cnt_reg == HOLD) begin
                        state_reg <= IDLE;
                        acu_oe    <= 1'b0;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        done0     <= 1'b0;
                        done1     <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                        done0   <= ((cnt_reg + 4'd1) == HOLD) && !owner_reg;
                        done1   <= ((cnt_reg + 4'd1) == HOLD) && owner_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // cnt_reg tracks the number of the current acu_oe cycle, starting at 1.
            if (start_drive) begin
                acu_oe  <= 1'b1;
                cnt_reg <= 4'd1;
                done0   <= hold_one && !owner_reg;
                done1   <= hold_one && owner_reg;
            end
        end
    end

endmodule

// File: tb/tb_acu_seq.sv
// Bench for acu_seq: two instances (hold 2 and hold 1) checked every cycle against a transaction-level model.
module tb_acu_seq;

`ifdef ACU_SEQ_HI_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_req0, a_req1, b_req0, b_req1;
    logic [15:0] a_addr0, a_addr1, b_addr0, b_addr1;
    logic        a_gnt0, a_gnt1, a_done0, a_done1, a_busy, a_wl, a_wh, a_oe;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_wl, b_wh, b_oe;
    logic [7:0]  a_d, b_d;
    logic [15:0] a_out, b_out;

    assign a_out = {a_gnt0, a_gnt1, a_done0, a_done1, a_busy, a_wl, a_wh, a_oe, a_d};
    assign b_out = {b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_wl, b_wh, b_oe, b_d};

    acu_seq #(.HOLD_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(a_req0), .addr0(a_addr0), .req1(a_req1), .addr1(a_addr1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1), .busy(a_busy),
        .acu_d(a_d), .acu_wl(a_wl), .acu_wh(a_wh), .acu_oe(a_oe)
    );

    acu_seq #(.HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .addr0(b_addr0), .req1(b_req1), .addr1(b_addr1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .busy(b_busy),
        .acu_d(b_d), .acu_wl(b_wl), .acu_wh(b_wh), .acu_oe(b_oe)
    );

    int checks = 0;
    int passed = 0;

    // Model: each granted transaction becomes a list of expected per-cycle output words.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        m_ptr[2];
    logic [7:0]  m_d[2];
    logic        m_hiv[2];
    logic [7:0]  m_hib[2];

    function automatic int hold_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [15:0] rec(input bit w, input bit dn, input bit wl, input bit wh,
                                        input bit oe, input logic [7:0] d);
        return {!w, w, dn && !w, dn && w, 1'b1, wl, wh, oe, d};
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 1'b1;
            m_d[k]   = 8'h00;
            m_hiv[k] = 1'b0;
            m_hib[k] = 8'h00;
        end
    endtask

    task automatic model_step(input int k, input logic r0, input logic [15:0] a0,
                              input logic r1, input logic [15:0] a1);
        logic [15:0] tr[$];
        logic [15:0] a;
        logic [15:0] tmp;
        logic [7:0]  d;
        bit          w;
        int          qs;
        qs = (k == 0) ? qa.size() : qb.size();
        if (qs != 0) begin
            if (k == 0) tmp = qa.pop_front();
            else        tmp = qb.pop_front();
        end else if (r0 || r1) begin
            if (r0 && r1) w = !m_ptr[k];
            else          w = r1;
            m_ptr[k] = w;
            a = w ? a1 : a0;
            d = a[7:0];
            tr.push_back(rec(w, 0, 1, 0, 0, d));
            if (!(SKIP && m_hiv[k] && (m_hib[k] == a[15:8]))) begin
                d = a[15:8];
                tr.push_back(rec(w, 0, 0, 1, 0, d));
                m_hib[k] = a[15:8];
                m_hiv[k] = 1'b1;
            end
            for (int i = 1; i <= hold_of(k); i++)
                tr.push_back(rec(w, i == hold_of(k), 0, 0, 1, d));
            m_d[k] = d;
            if (k == 0) qa = tr;
            else        qb = tr;
        end
    endtask

    function automatic logic [15:0] exp_of(input int k);
        if (k == 0) return (qa.size() != 0) ? qa[0] : {8'h00, m_d[0]};
        return (qb.size() != 0) ? qb[0] : {8'h00, m_d[1]};
    endfunction

    // Advance one clock; returns expected and observed {inst A, inst B} output words at the falling edge.
    task automatic tick(output logic [31:0] ev, output logic [31:0] av);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, a_req0, a_addr0, a_req1, a_addr1);
            model_step(1, b_req0, b_addr0, b_req1, b_addr1);
        end
        @(negedge clk);
        ev = {exp_of(0), exp_of(1)};
        av = {a_out, b_out};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {a_req0, a_req1, b_req0, b_req1} = 4'b0;
        {a_addr0, a_addr1, b_addr0, b_addr1} = {4{16'h0000}};
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a_out, b_out} !== 32'h0) $display("FAIL reset_outputs: got %h expected 00000000", {a_out, b_out});
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] ev, av;
        int lat;
        lat = -1;
        a_addr0 = 16'h4064;
        a_req0  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(ev, av);
            checks++;
            if (av !== ev) $display("FAIL basic cyc%0d: got %h expected %h", i, av, ev);
            else passed++;
            if (a_done0 && lat < 0) lat = i;
            if (ev[29]) a_req0 = 1'b0;
        end
        checks++;
        if (lat !== 4) $display("FAIL basic_latency: got %0d expected 4", lat);
        else passed++;
    endtask

    task automatic test_tie();
        logic [31:0] ev, av;
        logic [2:0]  order;
        int          n;
        apply_reset();
        order = 3'b000;
        n = 0;
        a_addr0 = 16'h1111;
        a_addr1 = 16'h2222;
        a_req0  = 1'b1;
        a_req1  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(ev, av);
            checks++;
            if (av !== ev) $display("FAIL tie cyc%0d: got %h expected %h", i, av, ev);
            else passed++;
            checks++;
            if (a_gnt0 && a_gnt1) $display("FAIL tie_both_gnt cyc%0d: got 11 expected not both", i);
            else passed++;
            if (a_wl && n < 3) begin
                order[2 - n] = a_gnt1;
                n++;
            end
            if (i == 15) begin
                a_req0 = 1'b0;
                a_req1 = 1'b0;
            end
        end
        checks++;
        if (n !== 3 || order !== 3'b010) $display("FAIL tie_order: got n=%0d order=%b expected n=3 order=010", n, order);
        else passed++;
    endtask

    task automatic test_midchange();
        logic [31:0] ev, av;
        int dones;
        dones = 0;
        a_addr0 = 16'h0020;
        a_req0  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(ev, av);
            checks++;
            if (av !== ev) $display("FAIL midchange cyc%0d: got %h expected %h", i, av, ev);
            else passed++;
            if (a_done0) dones++;
            if (i == 1) begin
                a_addr0 = 16'hFFFF;
                a_req0  = 1'b0;
            end
            if (i == 2) begin
                checks++;
                if (!(a_wh && a_d == 8'h00)) $display("FAIL midchange_hi: got wh=%b d=%h expected wh=1 d=00", a_wh, a_d);
                else passed++;
            end
        end
        checks++;
        if (dones !== 1) $display("FAIL midchange_done: got %0d pulses expected 1", dones);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] ev, av;
        logic [15:0] ad;
        ad = {8'hA5, 8'($urandom_range(0, 255))};
        a_addr0 = ad;
        a_req0  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(ev, av);
            checks++;
            if (av !== ev) $display("FAIL rstmid_pre cyc%0d: got %h expected %h", i, av, ev);
            else passed++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_oe, a_gnt0, a_busy, a_done0} !== 4'b0000)
            $display("FAIL rstmid_async: got oe/gnt/busy/done=%b expected 0000", {a_oe, a_gnt0, a_busy, a_done0});
        else passed++;
        tick(ev, av);
        checks++;
        if (av !== ev) $display("FAIL rstmid_hold: got %h expected %h", av, ev);
        else passed++;
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(ev, av);
            checks++;
            if (av !== ev) $display("FAIL rstmid_post cyc%0d: got %h expected %h", i, av, ev);
            else passed++;
            if (i == 1) begin
                checks++;
                if (!(a_wl && a_gnt0 && a_d == ad[7:0]))
                    $display("FAIL rstmid_restart: got wl=%b gnt0=%b d=%h expected 1 1 %h", a_wl, a_gnt0, a_d, ad[7:0]);
                else passed++;
            end
            if (ev[29]) a_req0 = 1'b0;
        end
    endtask

    task automatic test_skip();
        logic [31:0] ev, av;
        logic [15:0] addrs[3];
        int          lat, exp_lat;
        bit          saw_wh, exp_wh;
        logic [7:0]  wh_d;
        addrs = '{16'h2010, 16'h2033, 16'h2133};
        apply_reset();
        for (int t = 0; t < 3; t++) begin
            lat = -1;
            saw_wh = 1'b0;
            wh_d = 8'h00;
            a_addr0 = addrs[t];
            a_req0  = 1'b1;
            for (int i = 1; i <= 5; i++) begin
                tick(ev, av);
                checks++;
                if (av !== ev) $display("FAIL skip t%0d cyc%0d: got %h expected %h", t, i, av, ev);
                else passed++;
                if (a_done0 && lat < 0) lat = i;
                if (a_wh) begin
                    saw_wh = 1'b1;
                    wh_d = a_d;
                end
                if (ev[29]) a_req0 = 1'b0;
            end
            exp_wh  = !(SKIP && t == 1);
            exp_lat = exp_wh ? 4 : 3;
            checks++;
            if (lat !== exp_lat || saw_wh !== exp_wh)
                $display("FAIL skip_shape t%0d: got lat=%0d wh=%b expected lat=%0d wh=%b", t, lat, saw_wh, exp_lat, exp_wh);
            else passed++;
        end
        checks++;
        if (wh_d !== 8'h21) $display("FAIL skip_hi_byte: got %h expected 21", wh_d);
        else passed++;
    endtask

    task automatic test_hold1();
        logic [31:0] ev, av;
        logic [15:0] addrs[3];
        int          idx, nwl, t_wl[3], oe_cnt, oe_done, done_only;
        addrs = '{16'h3010, 16'h3020, 16'h3130};
        apply_reset();
        idx = 0; nwl = 0; oe_cnt = 0; oe_done = 0; done_only = 0;
        b_addr0 = addrs[0];
        b_req0  = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick(ev, av);
            checks++;
            if (av !== ev) $display("FAIL hold1 cyc%0d: got %h expected %h", i, av, ev);
            else passed++;
            if (b_wl && nwl < 3) begin
                t_wl[nwl] = i;
                nwl++;
            end
            if (b_oe) oe_cnt++;
            if (b_oe && b_done0) oe_done++;
            if (!b_oe && b_done0) done_only++;
            if (ev[13]) begin
                idx++;
                if (idx < 3) b_addr0 = addrs[idx];
                else b_req0 = 1'b0;
            end
        end
        checks++;
        if (nwl !== 3 || oe_cnt !== 3 || oe_done !== 3 || done_only !== 0)
            $display("FAIL hold1_pulses: got wl=%0d oe=%0d oe&done=%0d done_only=%0d expected 3 3 3 0",
                     nwl, oe_cnt, oe_done, done_only);
        else passed++;
        checks++;
        if (nwl == 3 && (t_wl[1] - t_wl[0] !== 4 || t_wl[2] - t_wl[1] !== (SKIP ? 3 : 4)))
            $display("FAIL hold1_period: got %0d,%0d expected 4,%0d", t_wl[1] - t_wl[0], t_wl[2] - t_wl[1], SKIP ? 3 : 4);
        else if (nwl == 3) passed++;
        else $display("FAIL hold1_period: got %0d grants expected 3", nwl);
    endtask

    task automatic test_random();
        logic [31:0] ev, av;
        for (int i = 1; i <= 400; i++) begin
            a_req0  = ($urandom_range(0, 3) != 0);
            a_req1  = ($urandom_range(0, 3) != 0);
            b_req0  = ($urandom_range(0, 2) != 0);
            b_req1  = ($urandom_range(0, 2) != 0);
            a_addr0 = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 255))};
            a_addr1 = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 255))};
            b_addr0 = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 255))};
            b_addr1 = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 255))};
            tick(ev, av);
            checks++;
            if (av !== ev) $display("FAIL random cyc%0d: got %h expected %h", i, av, ev);
            else passed++;
        end
        {a_req0, a_req1, b_req0, b_req1} = 4'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_midchange();
        test_reset_mid();
        test_skip();
        test_hold1();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
